// File: rtl/cpu_pkg.sv
// Shared datapath definitions for the single-cycle CPU: address width,
// reset PC, instruction size and the address type.
package cpu_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;

    typedef logic [XLEN-1:0] addr_t;

    localparam addr_t PC_RESET = 32'h0000_0000;

    // True when the low two address bits select a non-word boundary.
    function automatic logic word_misaligned(input logic [1:0] low_bits);
        return |low_bits;
    endfunction

endpackage : cpu_pkg

// File: rtl/pc_incrementer.sv
// Constant adder: sum = a + INCR, wrapping modulo 2^WIDTH. Shared by the
// sequential-PC path and the branch-target path.
module pc_incrementer
    import cpu_pkg::*;
#(
    parameter int WIDTH = XLEN,
    parameter int INCR  = INSTR_BYTES
) (
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] sum
);

    logic [WIDTH-1:0] incr_s;

    assign incr_s = WIDTH'(INCR);

    // Plain modular add; the carry out is deliberately discarded.
    always_comb begin
        sum = a + incr_s;
    end

endmodule : pc_incrementer

// File: rtl/program_counter.sv
// Architectural PC register. Loads the upstream-selected next PC on every
// rising edge and exposes pc + 4 and a word-alignment flag alongside it.
module program_counter
    import cpu_pkg::*;
#(
    parameter int               WIDTH       = XLEN,
    parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(PC_RESET)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] next,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus4,
    output logic             misaligned
);

    logic [WIDTH-1:0] pc_r;
    logic [WIDTH-1:0] pc_plus4_s;

    // PC register: async active-low clear, otherwise load next unconditionally
    // (stalls are expressed upstream by feeding pc back into next).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_r <= RESET_VALUE;
        end else begin
            pc_r <= next;
        end
    end

    pc_incrementer #(
        .WIDTH (WIDTH),
        .INCR  (INSTR_BYTES)
    ) u_seq_incr (
        .a   (pc_r),
        .sum (pc_plus4_s)
    );

    assign pc       = pc_r;
    assign pc_plus4 = pc_plus4_s;

    // Alignment flag follows the registered PC in the same cycle.
    always_comb begin
        misaligned = word_misaligned(pc_r[1:0]);
    end

endmodule : program_counter

// File: tb/tb_program_counter.sv
// Directed bench for program_counter: an abstract expected-PC model plus a
// negedge comparator, and literal checks at the key points of the sequence.
module tb_program_counter;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] next  = 32'h0000_0000;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        misaligned;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic        check_en = 1'b0;
    logic [31:0] exp_pc   = 32'h0000_0000;

    program_counter dut (
        .clk        (clk),
        .reset      (reset),
        .next       (next),
        .pc         (pc),
        .pc_plus4   (pc_plus4),
        .misaligned (misaligned)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: outputs are derived from the expected PC by plain arithmetic.
    always @(negedge clk) begin
        if (check_en) begin
            chk("model_pc", pc, exp_pc);
            chk("model_pc_plus4", pc_plus4, exp_pc + 32'd4);
            chk("model_misaligned", {31'd0, misaligned}, {31'd0, (exp_pc % 32'd4) != 32'd0});
        end
    end

    // Apply one next value across a rising edge; model loads it if out of reset.
    task automatic step(input logic [31:0] v);
        next = v;
        @(posedge clk);
        #1;
        if (reset) exp_pc = v;
    endtask

    initial begin
        // Reset while clocking, next pointing elsewhere.
        #1;
        reset  = 1'b0;
        exp_pc = 32'h0000_0000;
        #1;
        check_en = 1'b1;
        for (int i = 0; i < 4; i++) step(32'h0000_0008);
        chk("reset_pc", pc, 32'h0000_0000);
        chk("reset_pc_plus4", pc_plus4, 32'h0000_0004);
        chk("reset_misaligned", {31'd0, misaligned}, 32'd0);

        // Release and load sequentially.
        reset = 1'b1;
        step(32'h0000_0004);
        chk("seq_pc_4", pc, 32'h0000_0004);
        chk("seq_plus4_8", pc_plus4, 32'h0000_0008);
        step(32'h0000_0008);
        chk("seq_pc_8", pc, 32'h0000_0008);
        chk("seq_plus4_c", pc_plus4, 32'h0000_000C);
        step(32'h0000_002C);
        chk("seq_pc_2c", pc, 32'h0000_002C);
        chk("seq_plus4_30", pc_plus4, 32'h0000_0030);

        // Hold.
        step(32'h0000_002C);
        step(32'h0000_002C);
        chk("hold_pc", pc, 32'h0000_002C);

        // Asynchronous reset between edges.
        #2;
        reset = 1'b0;
        exp_pc = 32'h0000_0000;
        #1;
        chk("async_reset_pc", pc, 32'h0000_0000);
        chk("async_reset_plus4", pc_plus4, 32'h0000_0004);
        next = 32'h0000_0010;
        @(posedge clk);
        #1;
        chk("held_in_reset", pc, 32'h0000_0000);
        reset = 1'b1;
        step(32'h0000_0010);
        chk("release_pc_10", pc, 32'h0000_0010);

        // Wrap and alignment.
        step(32'hFFFF_FFFC);
        chk("wrap_pc", pc, 32'hFFFF_FFFC);
        chk("wrap_plus4", pc_plus4, 32'h0000_0000);
        step(32'h0000_0006);
        chk("mis_pc_6", pc, 32'h0000_0006);
        chk("mis_flag_1", {31'd0, misaligned}, 32'd1);
        chk("mis_plus4_a", pc_plus4, 32'h0000_000A);
        step(32'h0000_0008);
        chk("mis_flag_0", {31'd0, misaligned}, 32'd0);
        step(32'h0000_0003);
        chk("mis_flag_3", {31'd0, misaligned}, 32'd1);

        @(negedge clk);
        check_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_program_counter

// File: doc/program_counter.md
# program_counter

Architectural program-counter register for the single-cycle CPU datapath. Each rising clock edge it loads the next-PC value computed upstream by branch/jump/increment logic. It drives the current PC to instruction fetch and to the PC-relative adders. It also provides the sequential address (PC + 4) and an instruction-alignment flag, so downstream logic needs no separate adder.

## Interface
Parameters:
- WIDTH, 32, address width in bits; must be ≥ 3.
- RESET_VALUE, 32'h0000_0000, PC value while in reset; must be 4-byte aligned.

Ports:
- clk  input  1  single system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- next  input  WIDTH  next-PC value, selected upstream.
- pc  output  WIDTH  current PC, registered.
- pc_plus4  output  WIDTH  combinational pc + 4, modulo 2^WIDTH.
- misaligned  output  1  combinational; high when pc[1:0] != 2'b00.

## Operation
- One WIDTH-bit register holds the PC.
- reset low: the register is forced to RESET_VALUE immediately, with no clock edge needed, and is held there for as long as reset stays low. The next input is ignored.
- reset high: on every rising clk edge, pc <= next, unconditionally. There is no enable or stall input; holding the PC is done upstream by driving next = pc.
- next is loaded verbatim, including misaligned values; the block performs no masking or trapping.
- pc_plus4 = pc + 4. It wraps at 2^WIDTH: pc = 32'hFFFF_FFFC gives pc_plus4 = 32'h0000_0000. There is no carry output.
- misaligned = |pc[1:0]. It is 0 while in reset, because RESET_VALUE is aligned.

## Timing
- Latency: a value on next appears on pc one cycle later, after the capturing edge.
- pc_plus4 and misaligned follow pc combinationally, in the same cycle as pc.
- Reset values: pc = RESET_VALUE, pc_plus4 = RESET_VALUE + 4, misaligned = 0.
- Reset asserted mid-operation, between edges: pc changes to RESET_VALUE asynchronously, without waiting for clk.
- Reset deassertion: the first rising edge with reset high loads next. The deassertion must meet recovery/removal timing relative to clk; a reset synchronizer is external to this block.
- Holding next constant across cycles keeps pc constant, with no spurious updates.

## Structure
- Shared datapath package `cpu_pkg` holds:
  - `XLEN = 32`
  - `PC_RESET = 32'h0000_0000`
  - `INSTR_BYTES = 4`
  - typedef `addr_t = logic [XLEN-1:0]`
- The WIDTH and RESET_VALUE parameter defaults come from `cpu_pkg`.
- Sub-module `pc_incrementer`: a parameterized constant adder computing pc + INSTR_BYTES. It is reused by the branch-target path.
- The PC register itself is a single `always_ff` block in the top.

## Test plan
- Reset while clocking: reset = 0, next = 32'h8 for several edges -> pc = 0, pc_plus4 = 4, misaligned = 0, and pc never takes the value 8.
- Sequential load: release reset, next = 32'h4 -> pc = 4 after one edge; next = 32'h8 -> pc = 8; next = 32'h2C -> pc = 32'h2C; pc_plus4 tracks as 8, 32'hC, then 32'h30.
- Hold: next held at 32'h2C for two edges -> pc stays 32'h2C.
- Asynchronous reset mid-run: pc = 32'h2C, drop reset between edges -> pc = 0 before the next rising edge. Release reset with next = 32'h10 -> pc = 32'h10 after the first edge.
- Wrap and alignment: next = 32'hFFFF_FFFC -> pc_plus4 = 0. next = 32'h0000_0006 -> pc = 6 and misaligned = 1; then next = 32'h8 -> misaligned = 0.
